// File: rtl/cpu_bus_master.sv
// Queued command master for a phi2-clocked peripheral bus: write, read and masked poll
// cycles, one in-order response per command.
module cpu_bus_master #(
  parameter int DEPTH    = 4,
  parameter int POLL_MAX = 255
) (
  input  logic       phi2,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [9:0] cmd_addr,
  input  logic       cmd_rs0,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_mask,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [9:0] A,
  output logic       RS0,
  output logic       CS1,
  output logic       we_n,
  output logic [7:0] DO,
  output logic       OE,
  input  logic [7:0] DI,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO   = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [15:0]   POLL_LIMIT = 16'(POLL_MAX);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_GAP, ST_RESP} state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [9:0] addr;
    logic       rs0;
    logic [7:0] data;
    logic [7:0] mask;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  cmd_t          cur_q, cur_d;
  state_e        state_q, state_d;
  logic [15:0]   poll_cnt_q, poll_cnt_d;
  logic          push_s, pop_s;

  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  logic       busy_q, busy_d;
  logic [9:0] a_q, a_d;
  logic       rs0_q, rs0_d, cs1_q, cs1_d, we_n_q, we_n_d, oe_q, oe_d;
  logic [7:0] do_q, do_d;

  // Queue bookkeeping; cmd_ready is registered, so a full queue never takes a same-cycle push.
  always_comb begin
    push_s   = cmd_valid && cmd_ready_q;
    pop_s    = (state_q == ST_IDLE) && (count_q != CNT_ZERO) && !rsp_valid_q;
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Sequencer next state and response capture.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    poll_cnt_d    = poll_cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          cur_d      = mem_q[rd_ptr_q];
          poll_cnt_d = 16'd0;
          if (cur_d.op == OP_RSVD) begin
            state_d       = ST_RESP;
            rsp_data_d    = 8'h00;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d = ST_BUS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        case (cur_q.op)
          OP_WRITE: begin
            state_d       = ST_RESP;
            rsp_data_d    = cur_q.data;
            rsp_timeout_d = 1'b0;
          end
          OP_READ: begin
            state_d       = ST_RESP;
            rsp_data_d    = DI;
            rsp_timeout_d = 1'b0;
          end
          OP_POLL: begin
            if ((DI & cur_q.mask) == (cur_q.data & cur_q.mask)) begin
              state_d       = ST_RESP;
              rsp_data_d    = DI;
              rsp_timeout_d = 1'b0;
            end else begin
              poll_cnt_d = poll_cnt_q + 16'd1;
              if (poll_cnt_d == POLL_LIMIT) begin
                state_d       = ST_RESP;
                rsp_data_d    = DI;
                rsp_timeout_d = 1'b1;
              end else begin
                state_d = ST_GAP;
              end
            end
          end
          default: begin
            state_d       = ST_RESP;
            rsp_data_d    = 8'h00;
            rsp_timeout_d = 1'b0;
          end
        endcase
      end
      ST_GAP:  state_d = ST_BUS;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (count_d != CNT_ZERO) || (state_d != ST_IDLE);
    cmd_ready_d = (count_d != CNT_FULL);
    if (state_d == ST_BUS) begin
      a_d    = cur_d.addr;
      rs0_d  = cur_d.rs0;
      cs1_d  = 1'b1;
      we_n_d = (cur_d.op != OP_WRITE);
      oe_d   = (cur_d.op == OP_WRITE);
      do_d   = (cur_d.op == OP_WRITE) ? cur_d.data : 8'h00;
    end else begin
      a_d    = 10'h000;
      rs0_d  = 1'b0;
      cs1_d  = 1'b0;
      we_n_d = 1'b1;
      oe_d   = 1'b0;
      do_d   = 8'h00;
    end
  end

  // Queue storage.
  always_ff @(posedge phi2) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_rs0, cmd_data, cmd_mask};
    end
  end

  // State and output registers.
  always_ff @(posedge phi2) begin
    if (rst) begin
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
      cur_q         <= '{op: 2'b00, addr: 10'h000, rs0: 1'b0, data: 8'h00, mask: 8'h00};
      state_q       <= ST_IDLE;
      poll_cnt_q    <= 16'd0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      a_q           <= 10'h000;
      rs0_q         <= 1'b0;
      cs1_q         <= 1'b0;
      we_n_q        <= 1'b1;
      oe_q          <= 1'b0;
      do_q          <= 8'h00;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cur_q         <= cur_d;
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      a_q           <= a_d;
      rs0_q         <= rs0_d;
      cs1_q         <= cs1_d;
      we_n_q        <= we_n_d;
      oe_q          <= oe_d;
      do_q          <= do_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign A           = a_q;
  assign RS0         = rs0_q;
  assign CS1         = cs1_q;
  assign we_n        = we_n_q;
  assign OE          = oe_q;
  assign DO          = do_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master (DEPTH=4, POLL_MAX=4).
module tb_cpu_bus_master;

  logic       phi2 = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [9:0] cmd_addr = 10'h000;
  logic       cmd_rs0 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] cmd_mask = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [9:0] A;
  logic       RS0, CS1, we_n, OE, busy;
  logic [7:0] DO;
  logic [7:0] DI = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 phi2 = ~phi2;

  cpu_bus_master #(.DEPTH(4), .POLL_MAX(4)) dut (
    .phi2(phi2), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_rs0(cmd_rs0), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .A(A), .RS0(RS0), .CS1(CS1), .we_n(we_n), .DO(DO), .OE(OE), .DI(DI), .busy(busy)
  );

  // OE must never be driven during a read-direction bus cycle.
  always @(posedge phi2) begin
    if (!rst) begin
      checks++;
      if (OE === 1'b1 && we_n === 1'b1) begin
        errors++;
        $display("FAIL oe_with_read: OE=%0b we_n=%0b, required OE=0 when we_n=1", OE, we_n);
      end
    end
  end

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [9:0] addr, input logic rs0,
                          input logic [7:0] data, input logic [7:0] mask);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_wait: cmd_ready=%0b, required 1 within 20 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_rs0   = rs0;
    cmd_data  = data;
    cmd_mask  = mask;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cs1();
    int n = 0;
    while (CS1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (CS1 !== 1'b1) begin
      errors++;
      $display("FAIL bus_cycle_wait: CS1=%0b, required 1 within 20 cycles", CS1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 ||
        rsp_timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: ready=%0b rv=%0b rd=%h to=%0b busy=%0b, required 1 0 00 0 0",
               cmd_ready, rsp_valid, rsp_data, rsp_timeout, busy);
    end
    checks++;
    if (CS1 !== 1'b0 || we_n !== 1'b1 || OE !== 1'b0 || DO !== 8'h00 ||
        A !== 10'h000 || RS0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: CS1=%0b we_n=%0b OE=%0b DO=%h A=%h RS0=%0b, required 0 1 0 00 000 0",
               CS1, we_n, OE, DO, A, RS0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    push_cmd(2'b00, 10'h3C4, 1'b1, 8'h5A, 8'hFF);
    wait_cs1();
    checks++;
    if (A !== 10'h3C4 || DO !== 8'h5A || we_n !== 1'b0 || OE !== 1'b1 || RS0 !== 1'b1) begin
      errors++;
      $display("FAIL write_bus: A=%h DO=%h we_n=%0b OE=%0b RS0=%0b, required 3c4 5a 0 1 1",
               A, DO, we_n, OE, RS0);
    end
    tick();
    checks++;
    if (CS1 !== 1'b0 || OE !== 1'b0 || DO !== 8'h00 || A !== 10'h000) begin
      errors++;
      $display("FAIL write_one_cycle: CS1=%0b OE=%0b DO=%h A=%h, required idle bus", CS1, OE, DO, A);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: rv=%0b rd=%h to=%0b, required 1 5a 0", rsp_valid, rsp_data, rsp_timeout);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_done: rv=%0b busy=%0b, required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    DI = 8'hA5;
    push_cmd(2'b01, 10'h080, 1'b0, 8'h00, 8'hFF);
    wait_cs1();
    checks++;
    if (A !== 10'h080 || we_n !== 1'b1 || OE !== 1'b0 || DO !== 8'h00 || RS0 !== 1'b0) begin
      errors++;
      $display("FAIL read_bus: A=%h we_n=%0b OE=%0b DO=%h RS0=%0b, required 080 1 0 00 0",
               A, we_n, OE, DO, RS0);
    end
    tick();
    checks++;
    if (CS1 !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp: CS1=%0b rv=%0b rd=%h to=%0b, required 0 1 a5 0",
               CS1, rsp_valid, rsp_data, rsp_timeout);
    end
    tick();
  endtask

  task automatic test_poll();
    logic [15:0] pat = 16'h0000;
    int len = 0;
    int nbus = 0;
    rsp_ready = 1'b0;
    DI = 8'h00;
    push_cmd(2'b10, 10'h011, 1'b0, 8'h80, 8'h80);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid === 1'b1) break;
      if (len > 0 || CS1 === 1'b1) begin
        pat = {pat[14:0], CS1};
        len++;
      end
      if (CS1 === 1'b1) begin
        nbus++;
        DI = (nbus >= 4) ? 8'h80 : 8'h00;
      end
    end
    checks++;
    if (len != 7 || pat[6:0] !== 7'b1010101) begin
      errors++;
      $display("FAIL poll_pattern: len=%0d pat=%b, required 7 cycles 1010101", len, pat[6:0]);
    end
    checks++;
    if (nbus != 4 || rsp_valid !== 1'b1 || rsp_data !== 8'h80 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL poll_match: bus=%0d rv=%0b rd=%h to=%0b, required 4 1 80 0",
               nbus, rsp_valid, rsp_data, rsp_timeout);
    end
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h80) begin
      errors++;
      $display("FAIL poll_hold: rv=%0b rd=%h, required 1 80 while rsp_ready=0", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int nbus = 0;
    rsp_ready = 1'b0;
    DI = 8'h12;
    push_cmd(2'b10, 10'h2AA, 1'b1, 8'h55, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid === 1'b1) break;
      if (CS1 === 1'b1) nbus++;
    end
    checks++;
    if (nbus != 4 || rsp_valid !== 1'b1 || rsp_data !== 8'h12 || rsp_timeout !== 1'b1) begin
      errors++;
      $display("FAIL poll_timeout: bus=%0d rv=%0b rd=%h to=%0b, required 4 1 12 1",
               nbus, rsp_valid, rsp_data, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reserved();
    int nbus = 0;
    rsp_ready = 1'b0;
    push_cmd(2'b11, 10'h3FF, 1'b1, 8'h77, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1) break;
      if (CS1 === 1'b1) nbus++;
      tick();
    end
    checks++;
    if (nbus != 0 || rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op: bus=%0d rv=%0b rd=%h to=%0b, required 0 1 00 0",
               nbus, rsp_valid, rsp_data, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] expv [5] = '{8'h11, 8'h66, 8'h33, 8'h00, 8'h55};
    int idx = 0;
    rsp_ready = 1'b0;
    DI = 8'h66;
    push_cmd(2'b00, 10'h001, 1'b0, 8'h11, 8'hFF);
    push_cmd(2'b01, 10'h002, 1'b1, 8'h00, 8'hFF);
    push_cmd(2'b00, 10'h003, 1'b0, 8'h33, 8'hFF);
    push_cmd(2'b11, 10'h004, 1'b0, 8'h44, 8'hFF);
    push_cmd(2'b00, 10'h005, 1'b1, 8'h55, 8'hFF);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL queue_full: ready=%0b busy=%0b, required 0 1", cmd_ready, busy);
    end
    tick(); tick(); tick();
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin
      errors++;
      $display("FAIL queue_stall: ready=%0b rv=%0b rd=%h, required 0 1 11", cmd_ready, rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid === 1'b1 && idx < 5) begin
        checks++;
        if (rsp_data !== expv[idx]) begin
          errors++;
          $display("FAIL order_rsp%0d: rd=%h, required %h", idx, rsp_data, expv[idx]);
        end
        idx++;
      end
      if (idx == 5 && busy === 1'b0) break;
      tick();
    end
    checks++;
    if (idx != 5 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL order_count: responses=%0d ready=%0b busy=%0b, required 5 1 0", idx, cmd_ready, busy);
    end
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    rsp_ready = 1'b0;
    DI = 8'h33;
    push_cmd(2'b01, 10'h100, 1'b0, 8'h00, 8'hFF);
    push_cmd(2'b00, 10'h200, 1'b0, 8'h99, 8'hFF);
    wait_cs1();
    checks++;
    if (we_n !== 1'b1 || A !== 10'h100) begin
      errors++;
      $display("FAIL reset_mid_setup: we_n=%0b A=%h, required 1 100", we_n, A);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (CS1 !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: CS1=%0b rv=%0b ready=%0b busy=%0b, required 0 0 1 0",
               CS1, rsp_valid, cmd_ready, busy);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CS1 === 1'b1 || rsp_valid === 1'b1 || busy === 1'b1) activity++;
    end
    checks++;
    if (activity != 0) begin
      errors++;
      $display("FAIL reset_flush: active cycles=%0d, required 0", activity);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll();
    test_timeout();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
